// File: rtl/lab2_proc_mem_responder_pkg.sv
// Shared memory message definitions for the lab2 processor memory responder.
// Holds the request/response message structs, the type codes and small
// byte-lane helpers used by the responder.
package lab2_proc_mem_responder_pkg;

    localparam logic [2:0] c_mem_type_read  = 3'd0;
    localparam logic [2:0] c_mem_type_write = 3'd1;
    localparam logic [2:0] c_mem_type_init  = 3'd2;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Byte lanes touched by an access: len bytes (0 means 4) starting at off.
    // The 4-bit shift drops lanes past the word end, which is what truncates
    // unaligned accesses that would otherwise cross into the next word.
    function automatic logic [3:0] byte_lanes(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] base_s;
        logic [3:0] lanes_s;
        case (len)
            2'd1:    base_s = 4'b0001;
            2'd2:    base_s = 4'b0011;
            2'd3:    base_s = 4'b0111;
            default: base_s = 4'b1111;
        endcase
        lanes_s = base_s << off;
        return lanes_s;
    endfunction

    // Expand a 4-bit lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        logic [31:0] bits_s;
        bits_s = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            bits_s[8*b +: 8] = {8{lanes[b]}};
        end
        return bits_s;
    endfunction

endpackage

// File: rtl/lab2_proc_mem_responder_resp_queue.sv
// Response FIFO for the lab2 memory responder (module lab2_proc_mem_resp_queue).
// The upstream occupancy counter guarantees an enqueue never finds it full,
// so enqueue is unconditional.
module lab2_proc_mem_resp_queue
    import lab2_proc_mem_responder_pkg::*;
#(
    parameter int p_depth = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq_val,
    input  mem_resp_4B_t enq_msg,
    output logic         deq_val,
    input  logic         deq_rdy,
    output mem_resp_4B_t deq_msg
);

    localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_w = $clog2(p_depth + 1);

    mem_resp_4B_t       entries_r [p_depth];
    logic [c_ptr_w-1:0] wr_ptr_r;
    logic [c_ptr_w-1:0] rd_ptr_r;
    logic [c_cnt_w-1:0] count_r;
    logic               deq_s;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        if (p == c_ptr_w'(p_depth - 1)) begin
            return '0;
        end else begin
            return p + c_ptr_w'(1);
        end
    endfunction

    assign deq_val = (count_r != '0);
    assign deq_msg = entries_r[rd_ptr_r];
    assign deq_s   = deq_val & deq_rdy;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_val) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({enq_val, deq_s})
                2'b10:   count_r <= count_r + c_cnt_w'(1);
                2'b01:   count_r <= count_r - c_cnt_w'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; payload needs no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (enq_val) begin
            entries_r[wr_ptr_r] <= enq_msg;
        end
    end

endmodule

// File: rtl/lab2_proc_mem_responder.sv
// Memory-side responder for the processor imem/dmem val/rdy streams.
// Reads/writes/inits an internal word array in the accept cycle and returns
// in-order responses after p_latency cycles.
// Optional build macro: LAB2_PROC_MEM_RESP_ADDR_CHECK_EN -- out-of-range
// addresses are rejected with test=2'b01 instead of wrapping.
module lab2_proc_mem_responder
    import lab2_proc_mem_responder_pkg::*;
#(
    parameter int p_mem_nbytes   = 4096,
    parameter int p_latency      = 1,
    parameter int p_resp_q_depth = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqstream_val,
    output logic         reqstream_rdy,
    input  mem_req_4B_t  reqstream_msg,
    output logic         respstream_val,
    input  logic         respstream_rdy,
    output mem_resp_4B_t respstream_msg
);

    localparam int c_idx_w  = $clog2(p_mem_nbytes) - 2;
    localparam int c_nwords = p_mem_nbytes / 4;
    localparam int c_occ_w  = $clog2(p_resp_q_depth + 1);

    logic [31:0]        mem_r [c_nwords];
    logic [c_occ_w-1:0] occ_r;
    logic [c_occ_w-1:0] occ_next_s;
    logic               rdy_r;
    logic               accept_s;
    logic               fire_s;
    logic [c_idx_w-1:0] idx_s;
    logic [1:0]         off_s;
    logic [3:0]         lanes_s;
    logic [31:0]        word_s;
    logic [31:0]        wdata_s;
    logic               addr_ok_s;
    logic               wr_en_s;
    mem_resp_4B_t       resp_s;
    logic               push_val_s;
    mem_resp_4B_t       push_msg_s;

    assign accept_s      = reqstream_val & rdy_r;
    assign fire_s        = respstream_val & respstream_rdy;
    assign reqstream_rdy = rdy_r;

    assign idx_s   = reqstream_msg.addr[c_idx_w+1:2];
    assign off_s   = reqstream_msg.addr[1:0];
    assign lanes_s = byte_lanes(off_s, reqstream_msg.len);
    assign word_s  = mem_r[idx_s];
    assign wdata_s = reqstream_msg.data << {off_s, 3'b000};

`ifdef LAB2_PROC_MEM_RESP_ADDR_CHECK_EN
    assign addr_ok_s = (reqstream_msg.addr < 32'(p_mem_nbytes));
`else
    logic unused_addr_s;
    assign addr_ok_s     = 1'b1;
    assign unused_addr_s = ^reqstream_msg.addr[31:c_idx_w+2];
`endif

    // Build the response for the request at the input and decide on array update
    always_comb begin
        resp_s        = '0;
        resp_s.type_  = reqstream_msg.type_;
        resp_s.opaque = reqstream_msg.opaque;
        resp_s.len    = reqstream_msg.len;
        resp_s.test   = 2'b00;
        resp_s.data   = 32'h0000_0000;
        wr_en_s       = 1'b0;
        if (!addr_ok_s) begin
            resp_s.test = 2'b01;
        end else begin
            case (reqstream_msg.type_)
                c_mem_type_write,
                c_mem_type_init: wr_en_s = 1'b1;
                default:         resp_s.data = (word_s & lane_bits(lanes_s)) >> {off_s, 3'b000};
            endcase
        end
    end

    // Byte-enabled array update on accepted write/init (array is never reset)
    always_ff @(posedge clk) begin
        if (accept_s && wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Outstanding-request count: accepted but not yet delivered
    always_comb begin
        occ_next_s = occ_r;
        if (accept_s && !fire_s) begin
            occ_next_s = occ_r + c_occ_w'(1);
        end else if (!accept_s && fire_s) begin
            occ_next_s = occ_r - c_occ_w'(1);
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Occupancy register and registered request-ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_r <= '0;
            rdy_r <= 1'b0;
        end else begin
            occ_r <= occ_next_s;
            rdy_r <= (occ_next_s < c_occ_w'(p_resp_q_depth));
        end
    end

    // Extra latency stages; the queue push itself supplies the last cycle
    generate
        if (p_latency > 1) begin : g_pipe
            logic         val_r [p_latency-1];
            mem_resp_4B_t msg_r [p_latency-1];

            // Shift accepted responses toward the response queue
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < p_latency - 1; i++) begin
                        val_r[i] <= 1'b0;
                        msg_r[i] <= '0;
                    end
                end else begin
                    val_r[0] <= accept_s;
                    msg_r[0] <= resp_s;
                    for (int i = 1; i < p_latency - 1; i++) begin
                        val_r[i] <= val_r[i-1];
                        msg_r[i] <= msg_r[i-1];
                    end
                end
            end

            assign push_val_s = val_r[p_latency-2];
            assign push_msg_s = msg_r[p_latency-2];
        end else begin : g_nopipe
            assign push_val_s = accept_s;
            assign push_msg_s = resp_s;
        end
    endgenerate

    lab2_proc_mem_resp_queue #(
        .p_depth (p_resp_q_depth)
    ) u_resp_q (
        .clk     (clk),
        .reset   (reset),
        .enq_val (push_val_s),
        .enq_msg (push_msg_s),
        .deq_val (respstream_val),
        .deq_rdy (respstream_rdy),
        .deq_msg (respstream_msg)
    );

endmodule
